// File: rtl/ysyx_24100005_ifu.sv
// ysyx_24100005_ifu: single-outstanding instruction fetch feeding a {pc, inst} buffer toward decode
// Define YSYX_24100005_IFU_TRACE_EN to print every instruction handed to decode.
module ysyx_24100005_ifu #(
  parameter int              XLEN       = 32,
  parameter int              ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, r_addr, w_target;
  logic [ILEN-1:0] r_buf_inst [FIFO_DEPTH];
  logic [XLEN-1:0] r_buf_pc [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_count, w_cnt_nxt;
  logic            r_req_valid, w_fire, w_push, w_pop, w_space, w_busy;

  assign w_target  = redirect_pc & ~XLEN'(3);
  assign w_fire    = r_state == REQ && imem_req_ready;
  assign w_push    = r_state == WAIT && imem_rsp_valid && !redirect_valid;
  assign w_pop     = inst_valid && inst_ready;
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_space   = w_cnt_nxt < CW'(FIFO_DEPTH);
  // a request is in flight past this edge, so its response must be swallowed
  assign w_busy    = w_fire || ((r_state == WAIT || r_state == DROP) && !imem_rsp_valid);

  always_comb begin
    w_state_nxt = redirect_valid      ? (w_busy ? DROP : REQ)
                : r_state == IDLE     ? (w_space ? REQ : IDLE)
                : r_state == REQ      ? (imem_req_ready ? WAIT : REQ)
                : r_state == WAIT     ? (imem_rsp_valid ? (w_space ? REQ : IDLE) : WAIT)
                : (imem_rsp_valid ? REQ : DROP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_req_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_valid <= w_state_nxt == REQ;
      r_pc        <= redirect_valid ? w_target : w_fire ? r_pc + XLEN'(4) : r_pc;
      if (w_fire) r_addr <= r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_inst[r_wp] <= imem_rsp_data;
      r_buf_pc[r_wp]   <= r_addr;
    end
  end

`ifdef YSYX_24100005_IFU_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && w_pop && !redirect_valid) $display("pc=%h inst=%h opcode=%h", inst_pc, inst, inst[6:0]);
  end
`else
`endif

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign pc             = r_pc;
  assign inst_valid     = r_count != '0;
  assign inst           = r_buf_inst[r_rp];
  assign inst_pc        = r_buf_pc[r_rp];
endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// tb_ysyx_24100005_ifu: scoreboard bench; memory responder, decode monitor and directed scenarios
module tb_ysyx_24100005_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc, fetch_pc;

  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t q[$];
  int checks = 0, errors = 0, pops = 0;
  int n_acc = 0, allow = 0, lat = 1, cnt = 0, snap = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;

  ysyx_24100005_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .pc(fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  // memory: grants requests while n_acc < allow, answers each after lat cycles
  initial forever begin
    @(negedge clk); #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst) pend = 1'b0;
    else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(paddr);
        pend           = 1'b0;
      end
    end
    imem_req_ready = n_acc < allow;
    if (!rst && !pend && imem_req_valid && imem_req_ready) begin
      pend  = 1'b1;
      paddr = imem_req_addr;
      cnt   = lat;
      n_acc++;
    end
  end

  // monitor: every consumed head is matched against the scoreboard queue
  initial begin : mon
    ent_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        checks++;
        pops++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL pop: unexpected entry pc=%h inst=%h, none expected", inst_pc, inst);
        end else begin
          e = q.pop_front();
          if ({inst_pc, inst} !== e) begin
            errors++;
            $display("FAIL pop: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, e.pc, e.inst);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic grant(input int k);
    allow = n_acc + k;
  endtask

  task automatic wait_pops(input string name, input int n);
    int target;
    target = pops + n;
    for (int i = 0; i < 60 && pops < target; i++) begin
      @(negedge clk); #3;
    end
    checks++;
    if (pops < target) begin
      errors++;
      $display("FAIL %s: got %0d pops expected %0d", name, pops - target + n, n);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    inst_ready = 1'b1;
    @(negedge clk);
    grant(3);
    q.push_back({32'h8000_0000, 32'h25A5_0013});
    q.push_back({32'h8000_0004, 32'h25A5_0017});
    q.push_back({32'h8000_0008, 32'h25A5_001B});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("T1 reset pc", fetch_pc, 32'h8000_0000);
    chk("T1 reset req_valid", 32'(imem_req_valid), 0);
    chk("T1 reset inst_valid", 32'(inst_valid), 0);
    @(negedge clk);
    chk("T1 first req_valid", 32'(imem_req_valid), 1);
    chk("T1 first req_addr", imem_req_addr, 32'h8000_0000);
    wait_pops("T2 stream", 3);
    chk("T2 stalled req_valid", 32'(imem_req_valid), 1);
    chk("T2 stalled req_addr", imem_req_addr, 32'h8000_000C);
    chk("T2 inst_valid empty", 32'(inst_valid), 0);

    lat = 3;
    grant(1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1002;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("T3 pc after redirect", fetch_pc, 32'h8000_1000);
    chk("T3 req_valid in drop", 32'(imem_req_valid), 0);
    chk("T3 inst_valid flushed", 32'(inst_valid), 0);
    for (int i = 0; i < 10 && !imem_req_valid; i++) @(negedge clk);
    chk("T3 req_valid resumes", 32'(imem_req_valid), 1);
    chk("T3 req_addr target", imem_req_addr, 32'h8000_1000);
    lat = 1;
    q.push_back({32'h8000_1000, 32'h25A5_1013});
    grant(1);
    wait_pops("T3 first after redirect", 1);

    inst_ready = 1'b0;
    grant(10);
    repeat (10) @(negedge clk);
    chk("T4 full inst_valid", 32'(inst_valid), 1);
    chk("T4 full req_valid", 32'(imem_req_valid), 0);
    chk("T4 head inst_pc", inst_pc, 32'h8000_1004);
    chk("T4 head inst", inst, 32'h25A5_1017);
    chk("T4 pc", fetch_pc, 32'h8000_100C);
    snap = n_acc;
    q.push_back({32'h8000_1004, 32'h25A5_1017});
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("T4 new requests", 32'(n_acc - snap), 1);
    chk("T4 refill req_valid", 32'(imem_req_valid), 0);
    chk("T4 refill head inst_pc", inst_pc, 32'h8000_1008);
    chk("T4 refill pc", fetch_pc, 32'h8000_1010);

    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    grant(0);
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    chk("T6 inst_valid flushed", 32'(inst_valid), 0);
    chk("T6 pc target", fetch_pc, 32'h8000_2000);
    chk("T6 req_valid", 32'(imem_req_valid), 1);
    chk("T6 req_addr", imem_req_addr, 32'h8000_2000);
    q.push_back({32'h8000_2000, 32'h25A5_2013});
    q.push_back({32'h8000_2004, 32'h25A5_2017});
    inst_ready = 1'b1;
    grant(2);
    wait_pops("T6 after redirect", 2);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("T5 pc aligned", fetch_pc, 32'hFFFF_FFFC);
    chk("T5 req_addr", imem_req_addr, 32'hFFFF_FFFC);
    q.push_back({32'hFFFF_FFFC, 32'h5A5A_FFEF});
    q.push_back({32'h0000_0000, 32'hA5A5_0013});
    grant(2);
    wait_pops("T5 wrap", 2);
    chk("T5 pc after wrap", fetch_pc, 32'h0000_0004);
    chk("T5 req_addr after wrap", imem_req_addr, 32'h0000_0004);

    inst_ready = 1'b0;
    lat = 2;
    grant(5);
    repeat (12) @(negedge clk);
    chk("T7 full before reset", 32'(inst_valid), 1);
    chk("T7 head before reset", inst_pc, 32'h0000_0004);
    rst = 1'b1;
    grant(0);
    @(negedge clk);
    chk("T7 reset inst_valid", 32'(inst_valid), 0);
    chk("T7 reset req_valid", 32'(imem_req_valid), 0);
    chk("T7 reset pc", fetch_pc, 32'h8000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("T7 restart req_addr", imem_req_addr, 32'h8000_0000);
    q.push_back({32'h8000_0000, 32'h25A5_0013});
    inst_ready = 1'b1;
    lat = 1;
    grant(1);
    wait_pops("T7 restart", 1);

    chk("leftover expected entries", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
